// File: rtl/predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup in fetch; single-entry update from execute.

module btb_entry #(
    parameter int TAG = 26
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           we,
    input  logic           salto,
    input  logic [TAG-1:0] tag_w,
    input  logic [31:0]    destino,
    output logic           valid,
    output logic [TAG-1:0] tag,
    output logic [31:0]    target,
    output logic [1:0]     ctr
);
    logic hit_w;
    assign hit_w = valid && (tag == tag_w);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= 2'b01;
        end else if (we) begin
            if (hit_w) begin
                if (salto) begin
                    target <= destino;
                    if (ctr != 2'b11) ctr <= ctr + 2'd1;
                end else if (ctr != 2'b00) begin
                    ctr <= ctr - 2'd1;
                end
            end else if (salto) begin
                // Taken miss evicts whatever alias lived here
                valid  <= 1'b1;
                tag    <= tag_w;
                target <= destino;
                ctr    <= 2'b10;
            end
        end
    end
endmodule

module predictor_btb #(
    parameter int ENTRADAS = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pcf_i,
    output logic        hitF_o,
    output logic [1:0]  prediccionF_o,
    output logic        selbpF_o,
    output logic [31:0] pcbpF_o,
    input  logic        actualizarE_i,
    input  logic [31:0] pcE_i,
    input  logic        saltoE_i,
    input  logic [31:0] destinoE_i
);
    localparam int IDX = $clog2(ENTRADAS);
    localparam int TAG = 30 - IDX;

    logic [ENTRADAS-1:0]           valid;
    logic [ENTRADAS-1:0][TAG-1:0]  tag;
    logic [ENTRADAS-1:0][31:0]     target;
    logic [ENTRADAS-1:0][1:0]      ctr;

    logic [IDX-1:0] idx_f, idx_e;
    logic [TAG-1:0] tag_f, tag_e;
    logic           unused_pc_lsb;

    assign idx_f = pcf_i[IDX+1:2];
    assign tag_f = pcf_i[31:IDX+2];
    assign idx_e = pcE_i[IDX+1:2];
    assign tag_e = pcE_i[31:IDX+2];
    assign unused_pc_lsb = ^{pcf_i[1:0], pcE_i[1:0]};

    for (genvar i = 0; i < ENTRADAS; i++) begin : g_ent
        btb_entry #(.TAG(TAG)) u_ent (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .we      (actualizarE_i && (idx_e == IDX'(i))),
            .salto   (saltoE_i),
            .tag_w   (tag_e),
            .destino (destinoE_i),
            .valid   (valid[i]),
            .tag     (tag[i]),
            .target  (target[i]),
            .ctr     (ctr[i])
        );
    end

    // Reads registered state only, so a same-cycle update is seen next cycle
    always_comb begin
        hitF_o        = valid[idx_f] && (tag[idx_f] == tag_f);
        prediccionF_o = hitF_o ? ctr[idx_f] : 2'b00;
        pcbpF_o       = hitF_o ? target[idx_f] : 32'h0;
        selbpF_o      = hitF_o && ctr[idx_f][1];
    end
endmodule

// File: tb/tb_predictor_btb.sv
// Directed self-checking bench for predictor_btb (ENTRADAS=16: idx=pc[5:2], tag=pc[31:6]).

module tb_predictor_btb;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] pcf_i;
    logic        hitF_o;
    logic [1:0]  prediccionF_o;
    logic        selbpF_o;
    logic [31:0] pcbpF_o;
    logic        actualizarE_i;
    logic [31:0] pcE_i;
    logic        saltoE_i;
    logic [31:0] destinoE_i;

    int checks = 0;
    int failures = 0;

    predictor_btb #(.ENTRADAS(16)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pcf_i         (pcf_i),
        .hitF_o        (hitF_o),
        .prediccionF_o (prediccionF_o),
        .selbpF_o      (selbpF_o),
        .pcbpF_o       (pcbpF_o),
        .actualizarE_i (actualizarE_i),
        .pcE_i         (pcE_i),
        .saltoE_i      (saltoE_i),
        .destinoE_i    (destinoE_i)
    );

    always #5 clk_i = ~clk_i;

    // Drive one update cycle; returns on the negedge after the write edge.
    task automatic do_update(input logic [31:0] pc, input logic s, input logic [31:0] d);
        @(negedge clk_i);
        actualizarE_i = 1'b1; pcE_i = pc; saltoE_i = s; destinoE_i = d;
        @(negedge clk_i);
        actualizarE_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        pcf_i = 32'h100; #1;
        checks++; if (hitF_o !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hitF_o); end
        checks++; if (selbpF_o !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", selbpF_o); end
        checks++; if (pcbpF_o !== 32'h0) begin failures++; $display("FAIL reset_pcbp got=%h exp=0", pcbpF_o); end
        checks++; if (prediccionF_o !== 2'b00) begin failures++; $display("FAIL reset_pred got=%b exp=00", prediccionF_o); end
    endtask

    task automatic test_allocate();
        do_update(32'h100, 1'b1, 32'h200);
        pcf_i = 32'h100; #1;
        checks++; if (hitF_o !== 1'b1) begin failures++; $display("FAIL alloc_hit got=%b exp=1", hitF_o); end
        checks++; if (prediccionF_o !== 2'b10) begin failures++; $display("FAIL alloc_pred got=%b exp=10", prediccionF_o); end
        checks++; if (selbpF_o !== 1'b1) begin failures++; $display("FAIL alloc_sel got=%b exp=1", selbpF_o); end
        checks++; if (pcbpF_o !== 32'h200) begin failures++; $display("FAIL alloc_pcbp got=%h exp=200", pcbpF_o); end
        pcf_i = 32'h103; #1;
        checks++; if (hitF_o !== 1'b1) begin failures++; $display("FAIL lsb_ignored got=%b exp=1", hitF_o); end
    endtask

    task automatic test_counter();
        logic [1:0] exp_nt [3];
        exp_nt[0] = 2'b10; exp_nt[1] = 2'b01; exp_nt[2] = 2'b00;
        do_update(32'h100, 1'b1, 32'h200);
        pcf_i = 32'h100; #1;
        checks++; if (prediccionF_o !== 2'b11) begin failures++; $display("FAIL ctr_inc got=%b exp=11", prediccionF_o); end
        do_update(32'h100, 1'b1, 32'h204);
        #1;
        checks++; if (prediccionF_o !== 2'b11) begin failures++; $display("FAIL ctr_sat_hi got=%b exp=11", prediccionF_o); end
        checks++; if (pcbpF_o !== 32'h204) begin failures++; $display("FAIL tgt_update got=%h exp=204", pcbpF_o); end
        for (int k = 0; k < 3; k++) begin
            do_update(32'h100, 1'b0, 32'hFFFF_0000);
            #1;
            checks++; if (prediccionF_o !== exp_nt[k]) begin failures++; $display("FAIL ctr_dec%0d got=%b exp=%b", k, prediccionF_o, exp_nt[k]); end
        end
        do_update(32'h100, 1'b0, 32'h0);
        #1;
        checks++; if (prediccionF_o !== 2'b00) begin failures++; $display("FAIL ctr_sat_lo got=%b exp=00", prediccionF_o); end
        checks++; if (hitF_o !== 1'b1 || selbpF_o !== 1'b0) begin failures++; $display("FAIL nt_hit_sel got=%b%b exp=10", hitF_o, selbpF_o); end
        checks++; if (pcbpF_o !== 32'h204) begin failures++; $display("FAIL nt_tgt_hold got=%h exp=204", pcbpF_o); end
    endtask

    task automatic test_alias();
        pcf_i = 32'h140; #1;
        checks++; if (hitF_o !== 1'b0 || pcbpF_o !== 32'h0) begin failures++; $display("FAIL alias_miss got=%b/%h exp=0/0", hitF_o, pcbpF_o); end
        do_update(32'h140, 1'b1, 32'h500);
        pcf_i = 32'h100; #1;
        checks++; if (hitF_o !== 1'b0) begin failures++; $display("FAIL evicted got=%b exp=0", hitF_o); end
        pcf_i = 32'h140; #1;
        checks++; if (hitF_o !== 1'b1 || prediccionF_o !== 2'b10 || pcbpF_o !== 32'h500)
            begin failures++; $display("FAIL alias_alloc got=%b/%b/%h exp=1/10/500", hitF_o, prediccionF_o, pcbpF_o); end
    endtask

    task automatic test_isolation();
        do_update(32'h104, 1'b1, 32'h800);
        pcf_i = 32'h140; #1;
        checks++; if (hitF_o !== 1'b1 || pcbpF_o !== 32'h500) begin failures++; $display("FAIL other_hold got=%b/%h exp=1/500", hitF_o, pcbpF_o); end
        pcf_i = 32'h104; #1;
        checks++; if (pcbpF_o !== 32'h800) begin failures++; $display("FAIL idx1_tgt got=%h exp=800", pcbpF_o); end
        @(negedge clk_i);
        actualizarE_i = 1'b0; pcE_i = 32'h140; saltoE_i = 1'b1; destinoE_i = 32'hDEAD;
        @(negedge clk_i);
        pcf_i = 32'h140; #1;
        checks++; if (prediccionF_o !== 2'b10 || pcbpF_o !== 32'h500)
            begin failures++; $display("FAIL no_update_hold got=%b/%h exp=10/500", prediccionF_o, pcbpF_o); end
    endtask

    task automatic test_nt_miss();
        do_reset();
        do_update(32'h300, 1'b0, 32'h900);
        pcf_i = 32'h300; #1;
        checks++; if (hitF_o !== 1'b0 || pcbpF_o !== 32'h0) begin failures++; $display("FAIL nt_miss got=%b/%h exp=0/0", hitF_o, pcbpF_o); end
    endtask

    task automatic test_same_cycle();
        do_update(32'h100, 1'b1, 32'h200);
        @(negedge clk_i);
        actualizarE_i = 1'b1; pcE_i = 32'h100; saltoE_i = 1'b1; destinoE_i = 32'h300;
        pcf_i = 32'h100; #1;
        checks++; if (prediccionF_o !== 2'b10 || pcbpF_o !== 32'h200)
            begin failures++; $display("FAIL same_old got=%b/%h exp=10/200", prediccionF_o, pcbpF_o); end
        @(negedge clk_i);
        actualizarE_i = 1'b0; #1;
        checks++; if (prediccionF_o !== 2'b11 || pcbpF_o !== 32'h300)
            begin failures++; $display("FAIL same_new got=%b/%h exp=11/300", prediccionF_o, pcbpF_o); end
    endtask

    task automatic test_reset_update();
        @(negedge clk_i);
        reset_i = 1'b1; actualizarE_i = 1'b1; pcE_i = 32'h180; saltoE_i = 1'b1; destinoE_i = 32'h444;
        @(negedge clk_i);
        reset_i = 1'b0; actualizarE_i = 1'b0;
        pcf_i = 32'h180; #1;
        checks++; if (hitF_o !== 1'b0) begin failures++; $display("FAIL rst_prio got=%b exp=0", hitF_o); end
        pcf_i = 32'h100; #1;
        checks++; if (hitF_o !== 1'b0 || prediccionF_o !== 2'b00) begin failures++; $display("FAIL rst_mid got=%b/%b exp=0/00", hitF_o, prediccionF_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        actualizarE_i = 1'b1; pcE_i = 32'h100; saltoE_i = 1'b1; destinoE_i = 32'h600;
        @(negedge clk_i);
        destinoE_i = 32'h610;
        @(negedge clk_i);
        saltoE_i = 1'b0; destinoE_i = 32'h620;
        @(negedge clk_i);
        actualizarE_i = 1'b0;
        pcf_i = 32'h100; #1;
        // Alloc 10 -> taken 11 -> not-taken 10; target from last taken
        checks++; if (prediccionF_o !== 2'b10 || pcbpF_o !== 32'h610)
            begin failures++; $display("FAIL b2b got=%b/%h exp=10/610", prediccionF_o, pcbpF_o); end
    endtask

    initial begin
        reset_i = 1'b0; actualizarE_i = 1'b0; pcE_i = '0; saltoE_i = 1'b0;
        destinoE_i = '0; pcf_i = '0;
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_isolation();
        test_nt_miss();
        test_same_cycle();
        test_reset_update();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/predictor_btb.md
PREDICTOR_BTB -- requirements
Module: predictor_btb

Interface
REQ-001 The block SHALL have parameter ENTRADAS, default 16, number of direct-mapped BTB entries, power of two in range 4..64.
REQ-002 The block SHALL derive IDX = log2(ENTRADAS) and TAG = 30 - IDX.
REQ-003 The block SHALL have clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have reset_i  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have pcf_i  input  32  fetch-stage PC to look up.
REQ-006 The block SHALL have hitF_o  output  1  valid entry with matching tag exists for pcf_i.
REQ-007 The block SHALL have prediccionF_o  output  2  2-bit counter of the matching entry; 2'b00 on miss.
REQ-008 The block SHALL have selbpF_o  output  1  select predicted target as next PC.
REQ-009 The block SHALL have pcbpF_o  output  32  predicted target of the matching entry; 0 on miss.
REQ-010 The block SHALL have actualizarE_i  input  1  resolved branch/jump in execute, update request.
REQ-011 The block SHALL have pcE_i  input  32  PC of the resolved instruction.
REQ-012 The block SHALL have saltoE_i  input  1  branch actually taken.
REQ-013 The block SHALL have destinoE_i  input  32  actual branch target.

Function
REQ-014 Index SHALL be pc[IDX+1:2]; tag SHALL be pc[31:IDX+2]; pc[1:0] SHALL be ignored.
REQ-015 Each entry SHALL hold valid (1b), tag (TAG b), target (32b), counter (2b).
REQ-016 Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
REQ-017 Lookup SHALL be combinational from registered table state: zero-cycle latency from pcf_i to hitF_o/prediccionF_o/selbpF_o/pcbpF_o.
REQ-018 hitF_o SHALL be 1 iff entry[idx(pcf_i)].valid and tag matches tag(pcf_i).
REQ-019 selbpF_o SHALL equal hitF_o AND counter[1].
REQ-020 On miss, prediccionF_o, pcbpF_o and selbpF_o SHALL all be 0.
REQ-021 Update SHALL occur at the rising edge when actualizarE_i=1 and reset_i=0; one-cycle write latency.
REQ-022 Update hit is determined internally: entry[idx(pcE_i)] valid with tag equal to tag(pcE_i).
REQ-023 Update hit, saltoE_i=1: counter saturating increment (11 stays 11); target <= destinoE_i.
REQ-024 Update hit, saltoE_i=0: counter saturating decrement (00 stays 00); target unchanged.
REQ-025 Update miss, saltoE_i=1: allocate: valid<=1, tag<=tag(pcE_i), target<=destinoE_i, counter<=2'b10, replacing any prior occupant.
REQ-026 Update miss, saltoE_i=0: no table change.
REQ-027 Only the single indexed entry SHALL change per update; all other entries hold.
REQ-028 Simultaneous lookup and update of the same index: lookup in that cycle SHALL return pre-update contents (no bypass); new contents visible next cycle.
REQ-029 actualizarE_i=0: table SHALL hold regardless of pcE_i/saltoE_i/destinoE_i.
REQ-030 Aliasing (same index, different tag) SHALL report a miss, never a false hit.

Reset
REQ-031 When reset_i=1 at a rising edge, all entries SHALL become valid=0, tag=0, target=0, counter=2'b01 within that single cycle.
REQ-032 Reset SHALL take priority over a coincident update; the update is discarded.
REQ-033 In the cycle after reset, every lookup SHALL give hitF_o=0, prediccionF_o=00, selbpF_o=0, pcbpF_o=0.
REQ-034 Reset asserted mid-operation SHALL discard all learned state identically to power-up reset.

Verification
REQ-035 Reset, then pcf_i=0x100 -> hitF_o=0, selbpF_o=0, pcbpF_o=0, prediccionF_o=00.
REQ-036 Update pcE_i=0x100, saltoE_i=1, destinoE_i=0x200; next cycle pcf_i=0x100 -> hitF_o=1, prediccionF_o=10, selbpF_o=1, pcbpF_o=0x200.
REQ-037 From counter 10 at 0x100: two taken updates -> 11 (stays 11); three not-taken updates -> 10, 01, 00, then selbpF_o=0 with hitF_o=1.
REQ-038 Entry at 0x100 (ENTRADAS=16); lookup 0x140 (same index, different tag) -> hitF_o=0; taken update at 0x140 -> 0x100 now misses, 0x140 hits with counter 10.
REQ-039 Not-taken update on empty 0x300 -> next-cycle lookup 0x300 still misses.
REQ-040 Same-cycle update and lookup of 0x100 -> old values that cycle, new next cycle; reset coincident with update -> table empty afterwards.
